// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns, A..G bit indices and decoder FSM encoding.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SETTLING,
        ST_STABLE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: maps one lit-high A..G pattern to a BCD digit with legal/blank flags.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] digit_o,
    output logic       legal_o,
    output logic       blank_o
);

    assign blank_o = ~(pattern_i[SEG_A] | pattern_i[SEG_B] | pattern_i[SEG_C] | pattern_i[SEG_D] |
                       pattern_i[SEG_E] | pattern_i[SEG_F] | pattern_i[SEG_G]);

    always_comb begin
        digit_o = 4'd0;
        legal_o = 1'b1;
        case (pattern_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_pair_decoder.sv
// seg7_pair_decoder: debounces and decodes a two-digit 7-segment display into BCD,
// binary value and step/jump change pulses.
module seg7_pair_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 250000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [6:0] i_Seg_Tens,
    input  logic [6:0] i_Seg_Ones,
    output logic [3:0] o_Tens,
    output logic [3:0] o_Ones,
    output logic [6:0] o_Value,
    output logic       o_Valid,
    output logic       o_Error,
    output logic       o_Update,
    output logic       o_Step,
    output logic       o_Jump
);

    localparam int              CW        = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX   = CW'(STABLE_CYCLES - 1);
    localparam logic [13:0]     OFF_LEVEL = {14{ACTIVE_LOW}};

    logic [13:0]   sync1_q, sync2_q, prev_q, lit;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d, tens_dig, ones_dig;
    logic [6:0]    value_q, value_d, new_value, next_value;
    logic          valid_q, valid_d, error_q, error_d, have_q, have_d;
    logic          update_q, update_d, step_q, step_d, jump_q, jump_d;
    logic          tens_legal, tens_blank, ones_legal, ones_blank;
    logic          changed, accept, legal, is_step;

    // The decoders see the pattern being counted, so an acceptance that coincides
    // with the next input change still takes the pattern that earned it.
    assign lit = prev_q ^ OFF_LEVEL;

    seg7_pattern_decode u_tens (
        .pattern_i (lit[13:7]),
        .digit_o   (tens_dig),
        .legal_o   (tens_legal),
        .blank_o   (tens_blank)
    );

    seg7_pattern_decode u_ones (
        .pattern_i (lit[6:0]),
        .digit_o   (ones_dig),
        .legal_o   (ones_legal),
        .blank_o   (ones_blank)
    );

    assign changed    = sync2_q != prev_q;
    assign accept     = state_q == ST_SETTLING && cnt_q == CNT_MAX;
    assign legal      = (tens_legal | tens_blank) & ones_legal & ~ones_blank;
    assign new_value  = {3'b000, tens_dig} * 7'd10 + {3'b000, ones_dig};
    assign next_value = value_q == 7'd99 ? 7'd0 : value_q + 7'd1;
    assign is_step    = have_q && new_value == next_value;

    always_comb begin
        cnt_d    = changed ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        state_d  = changed ? ST_SETTLING : accept ? (legal ? ST_STABLE : ST_ERROR) : state_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        value_d  = value_q;
        valid_d  = valid_q;
        error_d  = error_q;
        have_d   = have_q;
        update_d = 1'b0;
        step_d   = 1'b0;
        jump_d   = 1'b0;
        if (accept) begin
            valid_d = legal;
            error_d = ~legal;
            if (legal && !(have_q && new_value == value_q)) begin
                update_d = 1'b1;
                step_d   = is_step;
                jump_d   = have_q & ~is_step;
                tens_d   = tens_dig;
                ones_d   = ones_dig;
                value_d  = new_value;
                have_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q  <= OFF_LEVEL;
            sync2_q  <= OFF_LEVEL;
            prev_q   <= OFF_LEVEL;
            cnt_q    <= '0;
            state_q  <= ST_EMPTY;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            value_q  <= 7'd0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            have_q   <= 1'b0;
            update_q <= 1'b0;
            step_q   <= 1'b0;
            jump_q   <= 1'b0;
        end else begin
            sync1_q  <= {i_Seg_Tens, i_Seg_Ones};
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
            have_q   <= have_d;
            update_q <= update_d;
            step_q   <= step_d;
            jump_q   <= jump_d;
        end
    end

    assign o_Tens   = tens_q;
    assign o_Ones   = ones_q;
    assign o_Value  = value_q;
    assign o_Valid  = valid_q;
    assign o_Error  = error_q;
    assign o_Update = update_q;
    assign o_Step   = step_q;
    assign o_Jump   = jump_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
// tb_seg7_pair_decoder: directed vector table, corner sequences and a randomized run
// checked cycle-by-cycle against a sample-window reference model.
module tb_seg7_pair_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_tens = 7'h7F;
    logic [6:0] seg_ones = 7'h7F;
    logic [3:0] o_tens, o_ones;
    logic [6:0] o_value;
    logic       o_valid, o_error, o_update, o_step, o_jump;

    int checks = 0;
    int errors = 0;

    seg7_pair_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Seg_Tens (seg_tens),
        .i_Seg_Ones (seg_ones),
        .o_Tens     (o_tens),
        .o_Ones     (o_ones),
        .o_Value    (o_value),
        .o_Valid    (o_valid),
        .o_Error    (o_error),
        .o_Update   (o_update),
        .o_Step     (o_step),
        .o_Jump     (o_jump)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    // codes: 0..9 digit, 10 all-off, 11 lit 1010101, 12 lit 0000001
    function automatic logic [6:0] lit_of(input int code);
        if (code < 10) return pat[code];
        if (code == 10) return 7'b0000000;
        if (code == 11) return 7'b1010101;
        return 7'b0000001;
    endfunction

    function automatic int dig(input logic [6:0] l);
        for (int i = 0; i < 10; i++) if (pat[i] == l) return i;
        return -1;
    endfunction

    function automatic logic [19:0] pack(input int t, input int o, input int v,
                                         input bit va, input bit er, input bit up,
                                         input bit st, input bit ju);
        return {4'(t), 4'(o), 7'(v), va, er, up, st, ju};
    endfunction

    wire [19:0] got = {o_tens, o_ones, o_value, o_valid, o_error, o_update, o_step, o_jump};

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got tens=%0d ones=%0d value=%0d v/e/u/s/j=%b, want tens=%0d ones=%0d value=%0d v/e/u/s/j=%b",
                     name, act[19:16], act[15:12], act[11:5], act[4:0],
                     exp[19:16], exp[15:12], exp[11:5], exp[4:0]);
        end
    endtask

    task automatic drive(input int t, input int o);
        seg_tens = ~lit_of(t);
        seg_ones = ~lit_of(o);
    endtask

    // Reference model: a pattern is accepted at the edge where the sampled input
    // has held for exactly S samples ending three edges earlier.
    logic [13:0] hist [$];
    int  m_tens, m_ones, m_value;
    bit  m_valid, m_err, m_upd, m_step, m_jump, m_have;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist = {};
            for (int i = 0; i < S + 4; i++) hist.push_back(14'h3FFF);
            m_tens = 0; m_ones = 0; m_value = 0;
            m_valid = 0; m_err = 0; m_upd = 0; m_step = 0; m_jump = 0; m_have = 0;
        end else begin
            int n, td, od, v;
            bit run;
            logic [13:0] r, l;
            hist.push_back({seg_tens, seg_ones});
            if (hist.size() > 32) void'(hist.pop_front());
            n = hist.size();
            m_upd = 0; m_step = 0; m_jump = 0;
            r = hist[n-4];
            run = hist[n-1-(S+3)] != r;
            for (int j = 3; j <= S + 2; j++) if (hist[n-1-j] != r) run = 0;
            if (run) begin
                l  = ~r;
                td = l[13:7] == 7'd0 ? 0 : dig(l[13:7]);
                od = dig(l[6:0]);
                if (td < 0 || od < 0) begin
                    m_valid = 0; m_err = 1;
                end else begin
                    v = td * 10 + od;
                    m_valid = 1; m_err = 0;
                    if (!(m_have && v == m_value)) begin
                        m_upd  = 1;
                        m_step = m_have && v == (m_value + 1) % 100;
                        m_jump = m_have && !m_step;
                        m_tens = td; m_ones = od; m_value = v; m_have = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk)
        if (!rst) check("model", got, pack(m_tens, m_ones, m_value, m_valid, m_err, m_upd, m_step, m_jump));

    typedef struct {
        int t; int o; int value;
        bit upd; bit step; bit jump; bit valid; bit err;
    } vec_t;

    vec_t vecs [14];

    task automatic hold_and_check(input string name, input int t, input int o, input int v,
                                  input bit up, input bit st, input bit ju, input bit va, input bit er);
        drive(t, o);
        repeat (S + 3) @(posedge clk);
        @(negedge clk);
        check(name, got, pack(v / 10, v % 10, v, va, er, up, st, ju));
    endtask

    initial begin
        vecs[0]  = '{10, 3,  3, 1, 0, 0, 1, 0};
        vecs[1]  = '{ 0, 9,  9, 1, 0, 1, 1, 0};
        vecs[2]  = '{ 1, 0, 10, 1, 1, 0, 1, 0};
        vecs[3]  = '{ 9, 9, 99, 1, 0, 1, 1, 0};
        vecs[4]  = '{ 0, 0,  0, 1, 1, 0, 1, 0};
        vecs[5]  = '{10, 2,  2, 1, 0, 1, 1, 0};
        vecs[6]  = '{ 0, 2,  2, 0, 0, 0, 1, 0};
        vecs[7]  = '{ 4, 2, 42, 1, 0, 1, 1, 0};
        vecs[8]  = '{ 4, 11, 42, 0, 0, 0, 0, 1};
        vecs[9]  = '{ 5, 7, 57, 1, 0, 1, 1, 0};
        vecs[10] = '{ 5, 10, 57, 0, 0, 0, 0, 1};
        vecs[11] = '{ 5, 8, 58, 1, 1, 0, 1, 0};
        vecs[12] = '{12, 8, 58, 0, 0, 0, 0, 1};
        vecs[13] = '{ 5, 8, 58, 0, 0, 0, 1, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", got, 20'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            hold_and_check($sformatf("vec%0d", i), vecs[i].t, vecs[i].o, vecs[i].value,
                           vecs[i].upd, vecs[i].step, vecs[i].jump, vecs[i].valid, vecs[i].err);

        hold_and_check("to42", 4, 2, 42, 1, 0, 1, 1, 0);
        drive(4, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(4, 2);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("glitch", {o_value, o_update}, {7'd42, 1'b0});
        end

        drive(1, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_mid", got, 20'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (S + 3) @(posedge clk);
        @(negedge clk);
        check("rst_requal", got, pack(1, 5, 15, 1, 0, 1, 0, 0));

        for (int k = 0; k < 300; k++) begin
            int tc, oc, h;
            tc = $urandom_range(0, 12);
            oc = $urandom_range(0, 12);
            drive(tc, oc);
            if ($urandom_range(0, 15) == 0) seg_ones = 7'($urandom);
            h = $urandom_range(1, 7);
            repeat (h) @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                #1 check("rnd_rst", got, 20'd0);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
